// File: rtl/data_memory.sv
// rtl/data_memory.sv - block-addressed 256-byte data memory behind the data cache
//
// Holds 64 four-byte blocks and completes one whole-block read or write per
// accepted request after LATENCY access cycles (IDLE -> ACCESS -> DONE).
//
// Ports:
//   clk        system clock, all state changes on the rising edge
//   reset      synchronous active-high reset
//   read       block read request (cache mem_read)
//   write      block write request (cache mem_write)
//   address    6-bit block address, block A = bytes 4A..4A+3
//   writedata  block to write, [7:0] -> byte 4A ... [31:24] -> byte 4A+3
//   readdata   registered read result, same byte ordering
//   busywait   high while a request is pending or in progress
//
// Optional feature macro: DMEM_RESET_CLEAR_EN - reset also zeroes the array.

module data_memory #(
    parameter int LATENCY = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        read,
    input  logic        write,
    input  logic [5:0]  address,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        busywait
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_DONE
    } state_t;

    state_t      state;
    logic [3:0]  count;
    logic        op_write;
    logic [5:0]  addr_q;
    logic [31:0] data_q;
    logic [7:0]  mem [0:255];

    logic        commit;
    logic        request;
    logic [7:0]  base;

    // Exactly one of read/write is a legal request; both high is ignored.
    assign request = read ^ write;
    assign commit  = (state == S_ACCESS) && (count == 4'd0);
    assign base    = {addr_q, 2'b00};

    assign busywait = !reset &&
                      (((state == S_IDLE) && request) || (state == S_ACCESS));

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            count    <= 4'd0;
            readdata <= 32'h0;
            op_write <= 1'b0;
            addr_q   <= 6'd0;
            data_q   <= 32'h0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (request) begin
                        op_write <= write;
                        addr_q   <= address;
                        data_q   <= writedata;
                        count    <= 4'(LATENCY - 1);
                        state    <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (count != 4'd0) begin
                        count <= count - 4'd1;
                    end else begin
                        if (!op_write) begin
                            readdata <= {mem[base | 8'd3], mem[base | 8'd2],
                                         mem[base | 8'd1], mem[base]};
                        end
                        state <= S_DONE;
                    end
                end
                // The cache still holds its request during DONE, so inputs
                // are not sampled here.
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Array writes; reset on the commit edge suppresses the commit.
    always_ff @(posedge clk) begin
`ifdef DMEM_RESET_CLEAR_EN
        if (reset) begin
            for (int i = 0; i < 256; i++) begin
                mem[i] <= 8'h00;
            end
        end else if (commit && op_write) begin
            mem[base]        <= data_q[7:0];
            mem[base | 8'd1] <= data_q[15:8];
            mem[base | 8'd2] <= data_q[23:16];
            mem[base | 8'd3] <= data_q[31:24];
        end
`else
        if (!reset && commit && op_write) begin
            mem[base]        <= data_q[7:0];
            mem[base | 8'd1] <= data_q[15:8];
            mem[base | 8'd2] <= data_q[23:16];
            mem[base | 8'd3] <= data_q[31:24];
        end
`endif
    end

endmodule

// File: doc/data_memory.md
# data_memory

Block-addressed data memory that serves the data cache's refill and write-back traffic. It holds 256 bytes as 64 four-byte blocks and completes one whole-block read or write per request after a fixed, parameterised latency. It sits directly downstream of the data cache and drives that cache's `mem_busywait` and `mem_readdata` inputs. It uses a request/busywait handshake and an internal latency counter.

## Interface
- `LATENCY`, default 5: access cycles between request acceptance and completion; legal range 1..15.
- `clk`  input  1  system clock; all state updates on the rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `read`  input  1  block read request from the cache (`mem_read`).
- `write`  input  1  block write request from the cache (`mem_write`).
- `address`  input  6  block address {tag, index}; block A holds bytes 4A..4A+3.
- `writedata`  input  32  block to write; bits [7:0] go to byte 4A, bits [31:24] to byte 4A+3.
- `readdata`  output  32  registered block read result, same byte ordering as `writedata`.
- `busywait`  output  1  high while a request is pending or in progress.

## Operation
- Storage: 256 × 8-bit array; only whole 32-bit blocks are accessed.
- States: IDLE, ACCESS, DONE; a 4-bit down-counter `count` runs during ACCESS.
- IDLE, `read ^ write` high:
  - accepted at the clock edge;
  - latches `address`, `writedata` and the operation;
  - `count <= LATENCY-1`; next state ACCESS.
- IDLE, `read & write` both high: protocol error; the request is ignored, the block stays in IDLE and `busywait` stays 0.
- ACCESS, `count != 0`: `count` decrements.
- ACCESS, `count == 0`: the operation commits at that edge.
  - Read: `readdata` is loaded from the latched block.
  - Write: the 4 latched bytes are written to the array.
  - Next state DONE.
- DONE: lasts exactly one cycle, then IDLE.
  - `read`/`write` are ignored, because the cache still holds the request during this cycle.
  - A new request is only sampled once the block is back in IDLE.
- Inputs changing during ACCESS or DONE have no effect; latched values are used.
- `readdata` holds its value until the next read commits; a write does not change it.
- `busywait` is combinational: `(state==IDLE && (read ^ write)) || state==ACCESS`, forced to 0 while `reset` is high.

## Timing
- Request first asserted in cycle 0, with the block in IDLE:
  - `busywait` is high in cycles 0..LATENCY;
  - `busywait` is low in cycle LATENCY+1 (DONE);
  - read data is valid on `readdata` from cycle LATENCY+1.
- The cache sees `busywait` low at the edge ending the DONE cycle. At that same edge the block returns to IDLE.
- Minimum spacing between request starts: LATENCY+2 cycles.
- Reset values: state IDLE, `count` 0, `readdata` 32'h0, `busywait` 0.
- Reset mid-operation: the operation is aborted at the reset edge. Nothing is committed and the array is unchanged, unless `DMEM_RESET_CLEAR_EN` is defined.
- Reset arriving on the same edge as a commit: reset wins and no commit takes place.

## Configuration
- `DMEM_RESET_CLEAR_EN` defined: a synchronous reset also clears all 256 array bytes to 8'h00.
- `DMEM_RESET_CLEAR_EN` undefined: array contents are retained across reset; in simulation, contents are X until first written.

## Test plan
- Write then read back, LATENCY=5:
  - stimulus: write `address`=6'h05, `writedata`=32'hDEADBEEF, then a read of 6'h05;
  - `busywait` is high 6 cycles per request and low for 1 cycle;
  - `readdata`=32'hDEADBEEF in the DONE cycle;
  - byte 20 reads back as 8'hEF.
- Back-to-back requests: keep the request high through DONE and re-issue a read from cycle 7.
  - No extra operation occurs during DONE.
  - The second request is accepted in IDLE and completes at cycle 14.
- Input churn: change `address` and `writedata` to 6'h3F / 32'h12345678 during ACCESS of a write to 6'h00 with 32'hA5A5A5A5.
  - Block 0 holds 32'hA5A5A5A5.
  - Block 63 is unchanged.
- Illegal request: `read`=`write`=1 in IDLE.
  - `busywait` stays 0 and state stays IDLE.
  - Array and `readdata` are unchanged.
- Reset mid-write: assert `reset` in the 3rd ACCESS cycle of a write of 32'h11223344 to block 2.
  - `busywait` drops to 0.
  - `readdata` is 0.
  - Without the macro, block 2 retains its old value.
- With `DMEM_RESET_CLEAR_EN` defined: after reset, reading blocks 0 and 63 returns 32'h00000000. Repeat the tests with LATENCY=1 (`busywait` high 2 cycles).
